enable_period_monitor: RTL and testbench
========================================

// Module: enable_period_monitor
// PURPOSE
//  Receive-side checker for periodic single-cycle enable strobes (enable_gen output).
//  Measures clk cycles between consecutive strobes and flags early or late/missing strobes.
//  Reports lock once the strobe train is steady; streams each period over valid/ready.
//  Used for self-check of tick sources and as a field diagnostic on a debug bus.
// PARAMETERS
//  NOMINAL_PERIOD  20_000_001  expected cycles strobe-to-strobe (enable_gen ENABLE_CNT+1)
//  TOLERANCE       0           allowed +/- deviation in cycles; window [NOM-TOL, NOM+TOL]
//  LOCK_COUNT      4           consecutive in-window periods required to assert locked
//  W (local)       $clog2(NOMINAL_PERIOD+TOLERANCE+1)+1   counter/period width
// PORTS
//  clk           in   1  clock
//  resetn        in   1  async active-low reset
//  enable_in     in   1  strobe under test, synchronous to clk
//  clear         in   1  sync clear of sticky error flags
//  period_out    out  W  last measured period in cycles
//  period_valid  out  1  period_out holds an unconsumed measurement
//  period_ready  in   1  consumer accepts period_out when high with period_valid
//  locked        out  1  LOCK_COUNT consecutive in-window periods seen, no error since
//  err_fast      out  1  sticky: a period < NOMINAL_PERIOD-TOLERANCE was measured
//  err_slow      out  1  sticky: no strobe within NOMINAL_PERIOD+TOLERANCE cycles
// BEHAVIOUR
//  Reset: async, active-low; clk rising edge. Reset values: state=IDLE, cnt=0, run=0,
//   all outputs 0. Reset mid-measurement discards everything, incl. a pending period.
//  States: IDLE (no reference strobe), MEASURE (counting since last strobe).
//  IDLE: enable_in=1 -> MEASURE, cnt<=1. No measurement is produced.
//  MEASURE, enable_in=0: cnt<=cnt+1. If cnt==MAX (MAX=NOM+TOL) -> timeout:
//   err_slow<=1, locked<=0, run<=0, state<=IDLE. cnt never exceeds MAX.
//  MEASURE, enable_in=1: period P=cnt (back-to-back strobes give P=1); cnt<=1.
//   Strobe at cnt==MAX is in-window, not a timeout.
//   P<NOM-TOL: err_fast<=1, run<=0, locked<=0. Stay in MEASURE.
//   In-window: run<=min(run+1,LOCK_COUNT); locked<=1 when new run==LOCK_COUNT.
//   Every P (in- or out-of-window) is delivered on period_out.
//  Latency: strobe on clk edge k -> period_out/period_valid updated on edge k+1.
//  Handshake: period_valid stays high, period_out stable, until period_valid&&period_ready.
//   Cycle after accept, period_valid=0 unless a new P is loaded that same edge.
//   New P while a value is still pending: newest overwrites (no backpressure on strobes).
//   period_ready ignored while period_valid=0.
//  clear: err_fast/err_slow<=0, but an error event in the same cycle wins (flag =1).
//   clear does not affect state, cnt, run, locked or the period handshake.
//  enable_in held high continuously: P=1 each cycle -> err_fast unless NOM-TOL<=1.
//  Arithmetic: unsigned; window bounds computed at elaboration; NOM-TOL floors at 1.
// CONFIGURATION
//  `EPM_OVERRUN_EN defined: adds output err_overrun (1 bit, reset 0), set when a new P
//   overwrites a pending unaccepted one; sticky, cleared by clear (event wins).
//  Not defined: port absent; overwrite is silent, all other behaviour identical.
// TESTING  (NOMINAL_PERIOD=5, TOLERANCE=1, LOCK_COUNT=2, period_ready=1 unless stated)
//  1 Strobes every 5 cycles x4 -> period_out=5 x3, locked=1 edge after 3rd strobe, no errors.
//  2 Locked, then gap of 3 -> period_out=3, err_fast=1, locked=0; two gaps of 5 -> locked=1.
//  3 Gap 6 -> period_out=6, no error; gap >6 -> err_slow=1 at cnt==6, IDLE, next strobe no output.
//  4 period_ready=0 over two strobes (gaps 5 then 4) -> valid held, period_out 5 then 4;
//    err_overrun=1 with `EPM_OVERRUN_EN; ready=1 -> valid drops next cycle.
//  5 clear same cycle as fast strobe -> err_fast=1; clear alone later -> err_fast=0, locked kept.
//  6 resetn low mid-MEASURE with valid pending -> all outputs 0; first strobe after release
//    yields no period, second strobe 5 cycles later -> period_out=5.

Source files
------------

// File: rtl/enable_period_monitor.sv
// Strobe period checker: measures cycles between enable strobes, flags fast/slow.
// Optional build macro EPM_OVERRUN_EN adds the sticky err_overrun output.
module enable_period_monitor #(
  parameter int unsigned NOMINAL_PERIOD = 20_000_001,
  parameter int unsigned TOLERANCE      = 0,
  parameter int unsigned LOCK_COUNT     = 4,
  localparam int unsigned W =
    $clog2(NOMINAL_PERIOD + TOLERANCE + 1) + 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable_in,
  input  logic         clear,
  output logic [W-1:0] period_out,
  output logic         period_valid,
  input  logic         period_ready,
  output logic         locked,
  output logic         err_fast,
`ifdef EPM_OVERRUN_EN
  output logic         err_overrun,
`endif
  output logic         err_slow
);

  localparam int unsigned MAX = NOMINAL_PERIOD + TOLERANCE;
  localparam int unsigned LO  =
    (NOMINAL_PERIOD > TOLERANCE + 1) ?
    (NOMINAL_PERIOD - TOLERANCE) : 1;
  localparam int unsigned RWR = $clog2(LOCK_COUNT + 1);
  localparam int unsigned RW  = (RWR < 1) ? 1 : RWR;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [RW-1:0] run_q, run_d;
  logic [RW-1:0] run_inc;
  logic          locked_q, locked_d;
  logic [W-1:0]  period_q, period_d;
  logic          valid_q, valid_d;
  logic          efast_q, efast_d;
  logic          eslow_q, eslow_d;
  logic          fast_ev;
  logic          slow_ev;
  logic          load;

  // Saturating in-window run length
  always_comb begin
    run_inc = run_q;
    if (run_q != RW'(LOCK_COUNT)) begin
      run_inc = run_q + RW'(1);
    end
  end

  // Next state: counter, lock tracking, period handshake, sticky errors
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    locked_d = locked_q;
    period_d = period_q;
    valid_d  = valid_q;
    fast_ev  = 1'b0;
    slow_ev  = 1'b0;
    load     = 1'b0;
    if (valid_q && period_ready) begin
      valid_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (enable_in) begin
          state_d = MEASURE;
          cnt_d   = W'(1);
        end
      end
      MEASURE: begin
        if (enable_in) begin
          load     = 1'b1;
          period_d = cnt_q;
          valid_d  = 1'b1;
          cnt_d    = W'(1);
          if (cnt_q < W'(LO)) begin
            fast_ev  = 1'b1;
            run_d    = '0;
            locked_d = 1'b0;
          end else begin
            run_d = run_inc;
            if (run_inc == RW'(LOCK_COUNT)) begin
              locked_d = 1'b1;
            end
          end
        end else if (cnt_q == W'(MAX)) begin
          slow_ev  = 1'b1;
          locked_d = 1'b0;
          run_d    = '0;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    efast_d = (efast_q & ~clear) | fast_ev;
    eslow_d = (eslow_q & ~clear) | slow_ev;
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      period_q <= '0;
      valid_q  <= 1'b0;
      efast_q  <= 1'b0;
      eslow_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      efast_q  <= efast_d;
      eslow_q  <= eslow_d;
    end
  end

`ifdef EPM_OVERRUN_EN
  logic eovr_q, eovr_d;

  // Overrun: a new period replaces one the consumer has not taken
  always_comb begin
    eovr_d = (eovr_q & ~clear) |
             (load & valid_q & ~period_ready);
  end

  // Overrun flag register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      eovr_q <= 1'b0;
    end else begin
      eovr_q <= eovr_d;
    end
  end

  assign err_overrun = eovr_q;
`endif

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign err_fast     = efast_q;
  assign err_slow     = eslow_q;

endmodule

// File: tb/tb_enable_period_monitor.sv
// Scoreboard bench for enable_period_monitor (NOM=5, TOL=1, LOCK=2).
// Model works on strobe timestamps; monitor checks on the falling edge.
module tb_enable_period_monitor;

  localparam int NOM = 5;
  localparam int TOL = 1;
  localparam int LC  = 2;
  localparam int MAX = NOM + TOL;
  localparam int LO  = (NOM - TOL < 1) ? 1 : NOM - TOL;
  localparam int W   = $clog2(NOM + TOL + 1) + 1;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         enable_in = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] period_out;
  logic         period_valid;
  logic         period_ready = 1'b1;
  logic         locked;
  logic         err_fast;
  logic         err_slow;
`ifdef EPM_OVERRUN_EN
  logic         err_overrun;
`endif

  enable_period_monitor #(
    .NOMINAL_PERIOD(NOM),
    .TOLERANCE(TOL),
    .LOCK_COUNT(LC)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable_in(enable_in),
    .clear(clear),
    .period_out(period_out),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .locked(locked),
    .err_fast(err_fast),
`ifdef EPM_OVERRUN_EN
    .err_overrun(err_overrun),
`endif
    .err_slow(err_slow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit started = 0;

  // model state
  int  sbq[$];
  int  m_t = 0;
  int  m_last = 0;
  bit  m_ref, m_pend, m_locked, m_ef, m_es, m_ov;
  int  m_run;
  bit  p_en, p_rdy, p_clr, p_rst;

  task automatic chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", n, $time, act, exp);
    end
  endtask

  task automatic mreset();
    sbq.delete();
    m_ref = 0; m_pend = 0; m_locked = 0;
    m_ef = 0; m_es = 0; m_ov = 0; m_run = 0;
  endtask

  // advance the reference by one clock edge using the inputs it saw
  task automatic step();
    bit fev, sev, oev, prod;
    int p, el;
    fev = 0; sev = 0; oev = 0; prod = 0; p = 0;
    m_t++;
    if (!p_rst) begin
      mreset();
      return;
    end
    if (m_ref) begin
      el = m_t - m_last;
      if (p_en) begin
        p = el; prod = 1; m_last = m_t;
        if (p < LO) begin
          fev = 1; m_run = 0; m_locked = 0;
        end else begin
          if (m_run < LC) m_run++;
          if (m_run == LC) m_locked = 1;
        end
      end else if (el == MAX) begin
        sev = 1; m_ref = 0; m_run = 0; m_locked = 0;
      end
    end else if (p_en) begin
      m_ref = 1; m_last = m_t;
    end
    if (prod) begin
      if (m_pend && !p_rdy) begin
        oev = 1;
        if (sbq.size() > 0) void'(sbq.pop_back());
      end
      sbq.push_back(p);
      m_pend = 1;
    end else if (m_pend && p_rdy) begin
      m_pend = 0;
    end
    m_ef = (m_ef && !p_clr) || fev;
    m_es = (m_es && !p_clr) || sev;
    m_ov = (m_ov && !p_clr) || oev;
  endtask

  task automatic cyc(bit e, bit r, bit c, bit rs);
    @(posedge clk);
    #1;
    step();
    enable_in = e; period_ready = r; clear = c; resetn = rs;
    p_en = e; p_rdy = r; p_clr = c; p_rst = rs;
    if (!rs) mreset();
  endtask

  task automatic gap(int g, bit r = 1, bit c = 0);
    for (int i = 1; i < g; i++) cyc(0, r, 0, 1);
    cyc(1, r, c, 1);
  endtask

  // monitor: compares DUT outputs with the reference, pops on handshake
  always @(negedge clk) begin
    if (started) begin
      chk("valid", int'(period_valid), int'(m_pend));
      if (period_valid) begin
        if (sbq.size() == 0) begin
          chk("queue_empty", 1, 0);
        end else begin
          chk("period", int'(period_out), sbq[0]);
          if (period_ready) void'(sbq.pop_front());
        end
      end
      chk("locked", int'(locked), int'(m_locked));
      chk("err_fast", int'(err_fast), int'(m_ef));
      chk("err_slow", int'(err_slow), int'(m_es));
`ifdef EPM_OVERRUN_EN
      chk("err_overrun", int'(err_overrun), int'(m_ov));
`endif
      if (!resetn) chk("rst_out", int'(period_out), 0);
    end
  end

  initial begin
    int r, g, left;
    bit e, rd, c, rs;
    p_en = 0; p_rdy = 1; p_clr = 0; p_rst = 0;
    mreset();
    started = 1;
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    // steady train and lock
    cyc(1, 1, 0, 1);
    for (int i = 0; i < 3; i++) gap(5);
    // fast strobe then relock
    gap(3);
    gap(5);
    gap(5);
    // upper window edge, then timeout
    gap(6);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 1);
    gap(2);
    gap(5);
    // backpressure with overwrite
    gap(5, 0);
    gap(4, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    // clear racing a fast strobe, then clear alone
    gap(5); gap(5);
    gap(2, 1, 1);
    gap(5); gap(5); gap(5);
    cyc(0, 1, 1, 1);
    cyc(0, 1, 0, 1);
    // reset with a pending period
    gap(5, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    cyc(1, 1, 0, 1);
    gap(5);
    // enable held high
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 1);
    // randomized traffic
    left = 5;
    for (int i = 0; i < 3000; i++) begin
      e = 0;
      left--;
      if (left <= 0) begin
        e = 1;
        r = $urandom_range(0, 9);
        g = (r < 6) ? $urandom_range(4, 6) : $urandom_range(1, 9);
        left = g;
      end
      rd = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 499) != 0);
      cyc(e, rd, c, rs);
    end
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 1);
    @(posedge clk);
    #2;
    started = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
